// File: rtl/ws_pkg.sv
// Shared constants for the WS2812B frame sequencer:
// bit-generator mode codes, FSM states and frame geometry.
package ws_pkg;

  localparam logic [1:0] GEN_ZERO = 2'b10;
  localparam logic [1:0] GEN_ONE  = 2'b11;
  localparam logic [1:0] GEN_RET  = 2'b00;
  localparam logic [1:0] GEN_NONE = 2'b01;

  localparam int BITS_PER_LED = 24;
  localparam int CLK_HZ       = 100_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    RET   = 2'd3
  } state_t;

endpackage

// File: rtl/ws_ret_counter.sv
// RET (latch) period timer for the WS2812B frame sequencer.
// Ports: clk, reset (async, high), en (count while high),
// tc (1-cycle pulse on the RET_CYCLES-th enabled cycle).
module ws_ret_counter #(
  parameter int RET_CYCLES = 6000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(RET_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(RET_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  // Count restarts whenever the controller leaves RET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ws_frame_ctrl.sv
// WS2812B frame sequencer: fetches 24-bit GRB pixels over valid/ready,
// serialises them MSB-first into the bit generator, then times RET.
// Ports: clk, reset (async, high), start, pix_data/pix_valid/pix_ready,
// gen_mode/do_gen/gen_done (bit generator), busy, frame_done, underrun.
// Build option: WS_AUTO_REFRESH_EN restarts a frame after every RET.
module ws_frame_ctrl
  import ws_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int RET_CYCLES = 6000,
  parameter int LED_CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [1:0]  gen_mode,
  output logic        do_gen,
  input  logic        gen_done,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam logic [LED_CNT_W-1:0] LAST_LED = LED_CNT_W'(NUM_LEDS - 1);
  localparam logic [LED_CNT_W:0]   REQ_MAX  = (LED_CNT_W + 1)'(NUM_LEDS);
  localparam logic [4:0]           LAST_BIT = 5'(BITS_PER_LED - 1);

  state_t state, state_n;

  logic [23:0]          shift, shift_n;
  logic [23:0]          hold, hold_n;
  logic                 hold_full, hold_full_n;
  logic [4:0]           bit_cnt, bit_n;
  logic [LED_CNT_W-1:0] led_cnt, led_n;
  logic [LED_CNT_W:0]   req_cnt, req_n;

  logic       underrun_n, frame_done_n;
  logic       pix_ready_n, do_gen_n, busy_n;
  logic [1:0] gen_mode_n;

  logic        xfer, have_pix, ret_tc;
  logic [23:0] next_pix;

  ws_ret_counter #(
    .RET_CYCLES(RET_CYCLES)
  ) u_ret (
    .clk  (clk),
    .reset(reset),
    .en   (state == RET),
    .tc   (ret_tc)
  );

  always_comb begin
    xfer     = pix_valid & pix_ready;
    have_pix = hold_full | xfer;
    // pix_ready is never high while hold is full, so the
    // buffer and the bus are never both candidates.
    next_pix = hold_full ? hold : pix_data;

    state_n      = state;
    shift_n      = shift;
    hold_n       = hold;
    hold_full_n  = hold_full;
    bit_n        = bit_cnt;
    led_n        = led_cnt;
    req_n        = req_cnt + {{LED_CNT_W{1'b0}}, xfer};
    underrun_n   = underrun;
    frame_done_n = 1'b0;

    // Accepted pixels land in hold unless consumed below.
    if (xfer) begin
      hold_n      = pix_data;
      hold_full_n = 1'b1;
    end

    unique case (state)
      IDLE: begin
        // frame_done marks the cycle just after RET; a start
        // there belongs to the old frame and is dropped.
        if (start && !frame_done) begin
          underrun_n  = 1'b0;
          led_n       = '0;
          bit_n       = '0;
          req_n       = '0;
          hold_full_n = 1'b0;
          state_n     = FETCH;
        end
      end
      FETCH: begin
        if (have_pix) begin
          shift_n     = next_pix;
          hold_full_n = 1'b0;
          bit_n       = '0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (gen_done) begin
          if (bit_cnt == LAST_BIT) begin
            bit_n = '0;
            if (led_cnt == LAST_LED) begin
              state_n = RET;
            end else begin
              led_n = led_cnt + 1'b1;
              if (have_pix) begin
                shift_n     = next_pix;
                hold_full_n = 1'b0;
              end else begin
                underrun_n = 1'b1;
                state_n    = FETCH;
              end
            end
          end else begin
            shift_n = {shift[22:0], 1'b0};
            bit_n   = bit_cnt + 1'b1;
          end
        end
      end
      RET: begin
        if (ret_tc) begin
          frame_done_n = 1'b1;
`ifdef WS_AUTO_REFRESH_EN
          underrun_n  = 1'b0;
          led_n       = '0;
          bit_n       = '0;
          req_n       = '0;
          hold_full_n = 1'b0;
          state_n     = FETCH;
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from next-state values so they
    // line up with the state they describe.
    busy_n   = (state_n != IDLE);
    do_gen_n = (state_n == SEND);
    unique case (state_n)
      SEND:    gen_mode_n = shift_n[23] ? GEN_ONE : GEN_ZERO;
      RET:     gen_mode_n = GEN_RET;
      default: gen_mode_n = GEN_NONE;
    endcase
    pix_ready_n = busy_n && !hold_full_n &&
                  (req_n < REQ_MAX) && (state_n != RET);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      led_cnt    <= '0;
      req_cnt    <= '0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
      pix_ready  <= 1'b0;
      do_gen     <= 1'b0;
      busy       <= 1'b0;
      gen_mode   <= GEN_NONE;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      bit_cnt    <= bit_n;
      led_cnt    <= led_n;
      req_cnt    <= req_n;
      underrun   <= underrun_n;
      frame_done <= frame_done_n;
      pix_ready  <= pix_ready_n;
      do_gen     <= do_gen_n;
      busy       <= busy_n;
      gen_mode   <= gen_mode_n;
    end
  end

endmodule

// File: tb/tb_ws_frame_ctrl.sv
// Scoreboard bench for ws_frame_ctrl: a pixel source and bit-generator
// model drive the DUT; a monitor checks every serialised bit.
module tb_ws_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [1:0]  gen_mode;
  logic        do_gen;
  logic        gen_done;
  logic        busy;
  logic        frame_done;
  logic        underrun;

  logic gd_model = 1'b0;
  logic gd_force = 1'b0;
  assign gen_done = gd_model | gd_force;

  ws_frame_ctrl #(
    .NUM_LEDS  (2),
    .RET_CYCLES(6000),
    .LED_CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .gen_mode  (gen_mode),
    .do_gen    (do_gen),
    .gen_done  (gen_done),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;
  int bits_seen = 0;
  int gap_cnt = 0;
  int acc_cnt = 0;
  int period = 10;
  int gcnt = 0;

  logic [23:0] src_q[$];
  logic [1:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pixel source: expected bit modes are queued on acceptance.
  initial begin
    logic x;
    logic [23:0] p;
    forever begin
      @(negedge clk);
      x = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (x && src_q.size() > 0) begin
        p = src_q.pop_front();
        acc_cnt++;
        for (int b = 23; b >= 0; b--)
          exp_q.push_back(p[b] ? 2'b11 : 2'b10);
      end
      pix_valid = (src_q.size() > 0);
      pix_data  = (src_q.size() > 0) ? src_q[0] : 24'h0;
    end
  end

  // Bit generator: one gen_done every 'period' cycles of do_gen.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      gd_model = 1'b0;
      if (do_gen) begin
        gcnt++;
        if (gcnt >= period) begin
          gd_model = 1'b1;
          gcnt = 0;
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  // Monitor: each finished bit is compared with the scoreboard.
  always @(negedge clk) begin
    if (gd_model) begin
      bits_seen++;
      if (exp_q.size() == 0) begin
        check("bit_unexpected", 32'd1, 32'd0);
      end else begin
        check("bit_mode", {30'd0, gen_mode}, {30'd0, exp_q.pop_front()});
        check("bit_do_gen", {31'd0, do_gen}, 32'd1);
      end
    end
    if (busy && !do_gen && gen_mode == 2'b01 && bits_seen > 0)
      gap_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic clear_run();
    bits_seen = 0;
    gap_cnt = 0;
    acc_cnt = 0;
  endtask

  task automatic wait_bits(input int n, input string name);
    int k;
    k = 0;
    while (bits_seen < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check(name, (bits_seen >= n), 32'd1);
  endtask

  // Waits for RET, measures it, and probes start-on-frame_done.
  task automatic wait_ret(input logic exp_und, input int exp_acc);
    int k;
    k = 0;
    while (gen_mode != 2'b00 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("ret_reached", {30'd0, gen_mode}, 32'd0);
    check("ret_queue_empty", exp_q.size(), 32'd0);
    check("ret_accepted", acc_cnt, exp_acc);
    check("ret_underrun", {31'd0, underrun}, {31'd0, exp_und});
    k = 0;
    while (gen_mode == 2'b00 && k < 7000) begin
      k++;
      @(negedge clk);
    end
    check("ret_length", k, 32'd6000);
    check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("frame_done_width", {31'd0, frame_done}, 32'd0);
`ifdef WS_AUTO_REFRESH_EN
    check("auto_busy", {31'd0, busy}, 32'd1);
    check("auto_pix_ready", {31'd0, pix_ready}, 32'd1);
`else
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    src_q.delete();
    repeat (3) @(negedge clk);
    exp_q.delete();
    clear_run();
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_gen_mode", {30'd0, gen_mode}, 32'd1);
    check("rst_do_gen", {31'd0, do_gen}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // gen_done in IDLE with a pixel on offer: nothing moves.
    src_q.push_back(24'hA5A5A5);
    repeat (2) @(negedge clk);
    gd_force = 1'b1;
    @(negedge clk);
    gd_force = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_gd_busy", {31'd0, busy}, 32'd0);
    check("idle_gd_mode", {30'd0, gen_mode}, 32'd1);
    check("idle_gd_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("idle_gd_accepted", acc_cnt, 32'd0);

    // Reset mid-SEND, bit 10 of LED 1.
    period = 10;
    src_q.push_back(24'h3C3C3C);
    pulse_start();
    wait_bits(34, "t1_reach_bit");
    check("t1_sending", {31'd0, do_gen}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t1_do_gen", {31'd0, do_gen}, 32'd0);
    check("t1_gen_mode", {30'd0, gen_mode}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_pix_ready", {31'd0, pix_ready}, 32'd0);
    do_reset();

    // Two LEDs with prefetch; the third pixel must be refused.
    period = 122;
    src_q.push_back(24'hFF0000);
    src_q.push_back(24'h00FF01);
    src_q.push_back(24'h123456);
    pulse_start();
    wait_ret(1'b0, 2);
    check("t2_gap", gap_cnt, 32'd0);
    check("t2_bits", bits_seen, 32'd48);
    do_reset();

    // Second pixel withheld: underrun and a do_gen gap.
    period = 10;
    src_q.push_back(24'h0F0F0F);
    pulse_start();
    wait_bits(5, "t3_reach_bit5");
    pulse_start();
    @(negedge clk);
    check("t3_start_busy", {31'd0, busy}, 32'd1);
    check("t3_start_do_gen", {31'd0, do_gen}, 32'd1);
    check("t3_start_underrun", {31'd0, underrun}, 32'd0);
    wait_bits(24, "t3_reach_led_end");
    repeat (200) @(negedge clk);
    check("t3_underrun", {31'd0, underrun}, 32'd1);
    check("t3_gap_do_gen", {31'd0, do_gen}, 32'd0);
    src_q.push_back(24'hF0F0F1);
    wait_ret(1'b1, 2);
    check("t3_gap_len", (gap_cnt >= 200), 32'd1);
    check("t3_bits", bits_seen, 32'd48);
    pulse_start();
    @(negedge clk);
    check("t3_underrun_cleared", {31'd0, underrun}, 32'd0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
